// File: rtl/range_pkg.sv
// Shared types and helpers for the stream range tracker.
// Holds the window FSM states and the per-encoding extreme values.
package range_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } extremes_t;

   // Largest and smallest representable value for a w-bit sample.
   function automatic extremes_t extremes(
      input int unsigned w,
      input bit          signed_mode
   );
      logic [63:0] one;
      extremes_t   e;
      one = 64'd1;
      if (signed_mode) begin
         e.hi = 32'((one << (w - 1)) - one);
         e.lo = 32'(one << (w - 1));
      end else begin
         e.hi = 32'((one << w) - one);
         e.lo = 32'd0;
      end
      return e;
   endfunction

endpackage

// File: rtl/range_minmax_unit.sv
// Compare-and-update step for the running min/max pair.
// Equal samples leave both registers untouched.
module range_minmax_unit
   import range_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int SIGNED = 0
) (
   input  logic [DATA_W-1:0] cur_min,
   input  logic [DATA_W-1:0] cur_max,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] new_min,
   output logic [DATA_W-1:0] new_max
);

   logic lt_min;
   logic gt_max;

   // Strict compares in the selected encoding, then select.
   always_comb begin
      lt_min = 1'b0;
      gt_max = 1'b0;
      if (SIGNED != 0) begin
         lt_min = $signed(sample) < $signed(cur_min);
         gt_max = $signed(sample) > $signed(cur_max);
      end else begin
         lt_min = sample < cur_min;
         gt_max = sample > cur_max;
      end
      new_min = lt_min ? sample : cur_min;
      new_max = gt_max ? sample : cur_max;
   end

endmodule

// File: rtl/stream_range_tracker.sv
// Measures min, max, range and count of a sample stream
// over a go/finish window and holds the result until taken.
module stream_range_tracker
   import range_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              go,
   input  logic              finish,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              result_ready,
   output logic              result_valid,
   output logic [DATA_W-1:0] min_out,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W:0]   range_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              empty,
   output logic              error
);

   localparam extremes_t EXT = extremes(DATA_W, SIGNED != 0);
   localparam logic [DATA_W-1:0] MIN_INIT = EXT.hi[DATA_W-1:0];
   localparam logic [DATA_W-1:0] MAX_INIT = EXT.lo[DATA_W-1:0];

   state_t state_q;
   state_t state_d;

   logic err_d;
   logic start_win;
   logic accept;
   logic close_win;
   logic release_res;

   logic [DATA_W-1:0] min_q;
   logic [DATA_W-1:0] max_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [DATA_W-1:0] upd_min;
   logic [DATA_W-1:0] upd_max;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] fin_min;
   logic [DATA_W-1:0] fin_max;
   logic [CNT_W-1:0]  fin_cnt;
   logic [DATA_W:0]   ext_min;
   logic [DATA_W:0]   ext_max;
   logic [DATA_W:0]   diff;

   range_minmax_unit #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
   ) u_minmax (
      .cur_min (min_q),
      .cur_max (max_q),
      .sample  (sample_data),
      .new_min (upd_min),
      .new_max (upd_max)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state, window controls and protocol violations.
   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      start_win   = 1'b0;
      accept      = 1'b0;
      close_win   = 1'b0;
      release_res = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (finish) begin
               err_d = 1'b1;
            end else if (go) begin
               state_d   = TRACK;
               start_win = 1'b1;
            end
         end
         TRACK: begin
            accept = sample_valid;
            if (go) begin
               err_d = 1'b1;
            end else if (finish) begin
               state_d   = HOLD;
               close_win = 1'b1;
            end
         end
         HOLD: begin
            if (go || finish) begin
               err_d = 1'b1;
            end else if (result_ready) begin
               state_d     = IDLE;
               release_res = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Final values including a sample arriving with finish.
   always_comb begin
      cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                        : CNT_W'(cnt_q + 1'b1);
      fin_min = accept ? upd_min : min_q;
      fin_max = accept ? upd_max : max_q;
      fin_cnt = accept ? cnt_inc : cnt_q;
      if (SIGNED != 0) begin
         ext_min = {fin_min[DATA_W-1], fin_min};
         ext_max = {fin_max[DATA_W-1], fin_max};
      end else begin
         ext_min = {1'b0, fin_min};
         ext_max = {1'b0, fin_max};
      end
      diff = ext_max - ext_min;
   end

   // Running min/max/count for the open window.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         min_q <= '1;
         max_q <= '0;
         cnt_q <= '0;
      end else if (start_win) begin
         min_q <= MIN_INIT;
         max_q <= MAX_INIT;
         cnt_q <= '0;
      end else if (accept) begin
         min_q <= upd_min;
         max_q <= upd_max;
         cnt_q <= cnt_inc;
      end
   end

   // Result capture on close; cleared when the consumer takes it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_valid <= 1'b0;
         min_out      <= '0;
         max_out      <= '0;
         range_out    <= '0;
         count_out    <= '0;
         empty        <= 1'b0;
      end else if (close_win) begin
         result_valid <= 1'b1;
         count_out    <= fin_cnt;
         if (fin_cnt == '0) begin
            empty     <= 1'b1;
            min_out   <= '0;
            max_out   <= '0;
            range_out <= '0;
         end else begin
            empty     <= 1'b0;
            min_out   <= fin_min;
            max_out   <= fin_max;
            range_out <= diff;
         end
      end else if (release_res) begin
         result_valid <= 1'b0;
         min_out      <= '0;
         max_out      <= '0;
         range_out    <= '0;
         count_out    <= '0;
         empty        <= 1'b0;
      end
   end

   // One-cycle error pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) error <= 1'b0;
      else          error <= err_d;
   end

endmodule
